// File: rtl/uart_console_master.sv
// Wishbone master that configures a UART and then streams buffered bytes into
// its txdata register. Bytes arrive on a valid/ready port, are held in a small
// FIFO, and each is written only after a txdata poll shows the UART FIFO has room.
//
// Ports:
//   CLK_I, RST_I            clock, synchronous active-high reset
//   CYC_O STB_O WE_O ADR_O  Wishbone master request (registered)
//   DAT_O DAT_I ACK_I       Wishbone data out / read data / acknowledge
//   in_valid in_data        byte stream input
//   in_ready                byte stream ready (FIFO not full, low in reset)
//   init_done               UART div and txctrl written
//   busy                    FIFO holds bytes or a bus cycle is open
//   err                     sticky: some bus cycle timed out waiting for ACK_I
module uart_console_master #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned DIV_VALUE   = 86,
   parameter int unsigned NSTOP       = 0,
   parameter int unsigned RETRY_GAP   = 16,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   output logic [2:0]  ADR_O,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK_I,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        init_done,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned CW   = 16;

   localparam logic [2:0]    ADR_TXDATA = 3'd0;
   localparam logic [2:0]    ADR_TXCTRL = 3'd2;
   localparam logic [2:0]    ADR_DIV    = 3'd6;
   localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(RETRY_GAP - 1);
   localparam logic [31:0]   DIV_WORD   = {16'h0, 16'(DIV_VALUE)};
   localparam logic [31:0]   CTRL_WORD  = {30'h0, 1'(NSTOP), 1'b1};

   typedef enum logic [2:0] {
      S_BOOT, S_INIT_DIV, S_INIT_CTRL, S_IDLE, S_POLL, S_GAP, S_PUSH
   } state_e;

   state_e          state_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0] count_q;
   logic [CW-1:0]   cnt_q;
   logic            cyc_q, stb_q, we_q;
   logic [2:0]      adr_q;
   logic [31:0]     dat_q;
   logic            init_done_q, err_q;

   logic            fifo_full_c, push_c, pop_c, timeout_c, bus_done_c;
   logic            uart_full_c, remain_c;
   logic [7:0]      head_c;
   logic            unused_dat_c;

   // FIFO handshake and bus completion; a timeout completes the cycle like an ACK
   always_comb begin
      fifo_full_c = (count_q == CNTW'(FIFO_DEPTH));
      push_c      = in_valid && !fifo_full_c && !RST_I;
      timeout_c   = cyc_q && !ACK_I && (cnt_q == ACK_LAST);
      bus_done_c  = cyc_q && (ACK_I || timeout_c);
      pop_c       = (state_q == S_PUSH) && bus_done_c;
      uart_full_c = ACK_I && DAT_I[31];
      remain_c    = (count_q > CNTW'(1)) || push_c;
      head_c      = mem_q[rd_ptr_q];
   end

   assign unused_dat_c = ^DAT_I[30:0];

   assign in_ready  = !fifo_full_c && !RST_I;
   assign CYC_O     = cyc_q;
   assign STB_O     = stb_q;
   assign WE_O      = we_q;
   assign ADR_O     = adr_q;
   assign DAT_O     = dat_q;
   assign init_done = init_done_q;
   assign err       = err_q;
   assign busy      = (count_q != '0) || cyc_q;

   // Control FSM, FIFO storage and registered bus outputs
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q     <= S_BOOT;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CNTW'(push_c) - CNTW'(pop_c);
         if (timeout_c) begin
            err_q <= 1'b1;
         end
         // wait-cycle counter while a cycle is open
         if (cyc_q) begin
            cnt_q <= bus_done_c ? '0 : cnt_q + CW'(1);
         end

         // Bus states raise CYC_O on entry when coming from a non-bus state;
         // after a bus-to-bus hop CYC_O stays low for one cycle before relaunch.
         case (state_q)
            S_BOOT: begin
               state_q <= S_INIT_DIV;
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
               we_q    <= 1'b1;
               adr_q   <= ADR_DIV;
               dat_q   <= DIV_WORD;
            end
            S_INIT_DIV: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  we_q  <= 1'b1;
                  adr_q <= ADR_DIV;
                  dat_q <= DIV_WORD;
               end else if (bus_done_c) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= S_INIT_CTRL;
               end
            end
            S_INIT_CTRL: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  we_q  <= 1'b1;
                  adr_q <= ADR_TXCTRL;
                  dat_q <= CTRL_WORD;
               end else if (bus_done_c) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  init_done_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (count_q != '0) begin
                  state_q <= S_POLL;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b0;
                  adr_q   <= ADR_TXDATA;
                  dat_q   <= '0;
               end
            end
            S_POLL: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  we_q  <= 1'b0;
                  adr_q <= ADR_TXDATA;
                  dat_q <= '0;
               end else if (bus_done_c) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= uart_full_c ? S_GAP : S_PUSH;
               end
            end
            S_GAP: begin
               // relaunch on the last idle cycle so CYC_O is low exactly RETRY_GAP cycles
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_POLL;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b0;
                  adr_q   <= ADR_TXDATA;
                  dat_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_PUSH: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  we_q  <= 1'b1;
                  adr_q <= ADR_TXDATA;
                  dat_q <= {24'h0, head_c};
               end else if (bus_done_c) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= remain_c ? S_POLL : S_IDLE;
               end
            end
            default: state_q <= S_BOOT;
         endcase
      end
   end

endmodule

// File: doc/uart_console_master.md
UART_CONSOLE_MASTER -- requirements
Module: uart_console_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, byte-buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter DIV_VALUE, default 86, 16-bit baud divisor written to the UART div register.
REQ-003 SHALL have parameter NSTOP, default 0, written to txctrl bit 1.
REQ-004 SHALL have parameter RETRY_GAP, default 16, idle cycles between txdata polls when the UART TX FIFO is full.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 255, maximum cycles to wait for ACK_I.
REQ-006 SHALL have ports: CLK_I in 1, the one clock; RST_I in 1, reset, synchronous and active-high.
REQ-007 SHALL have Wishbone master ports: CYC_O out 1; STB_O out 1; WE_O out 1; ADR_O out 3, UART word address; DAT_O out 32; DAT_I in 32; ACK_I in 1.
REQ-008 SHALL have byte-stream ports: in_valid in 1; in_data in 8; in_ready out 1.
REQ-009 SHALL have status ports: init_done out 1, UART configured; busy out 1, FIFO non-empty or bus cycle open; err out 1, sticky ACK timeout.

Function
REQ-010 SHALL drive the UART at word addresses: txdata=0, txctrl=2, div=6.
REQ-011 SHALL accept a byte on any edge with in_valid=1 and in_ready=1, where in_ready = !fifo_full, including during init.
REQ-012 SHALL treat a push and a pop on the same edge as count-neutral; a push while full SHALL be impossible because in_ready=0.
REQ-013 SHALL use the FSM states BOOT, INIT_DIV, INIT_CTRL, IDLE, POLL, GAP, PUSH.
REQ-014 SHALL go BOOT -> INIT_DIV on the first edge after reset is released.
REQ-015 SHALL, in INIT_DIV, drive a write with ADR_O=6, DAT_O={16'b0,DIV_VALUE}, then go to INIT_CTRL on ACK_I.
REQ-016 SHALL, in INIT_CTRL, drive a write with ADR_O=2, DAT_O={30'b0,NSTOP,1'b1} (txen=1, watermark 0), then on ACK_I go to IDLE and set init_done=1.
REQ-017 SHALL go IDLE -> POLL when the FIFO is non-empty.
REQ-018 SHALL, in POLL, drive a read with ADR_O=0, WE_O=0; on ACK_I, DAT_I[31]=1 (UART full) -> GAP, else -> PUSH.
REQ-019 SHALL stay in GAP for exactly RETRY_GAP cycles with CYC_O=0, then return to POLL.
REQ-020 SHALL, in PUSH, drive a write with ADR_O=0, DAT_O={24'b0,fifo_head}; on ACK_I pop the FIFO, then go to POLL if bytes remain, else IDLE.
REQ-021 SHALL register bus outputs; a bus state SHALL hold CYC_O=STB_O=1 with constant ADR_O/DAT_O/WE_O from the state's entry cycle until the cycle after ACK_I.
REQ-022 SHALL deassert CYC_O/STB_O for at least one cycle between consecutive bus transactions.
REQ-023 SHALL ignore ACK_I while CYC_O=0.
REQ-024 SHALL count bus wait cycles and, if ACK_I is absent for ACK_TIMEOUT cycles, close the cycle, set err=1 (cleared only by reset) and take the ACK path, with DAT_I treated as 0 in POLL.
REQ-025 SHALL transmit bytes in acceptance order with no drop or duplication, except the single byte popped in PUSH on timeout.

Reset
REQ-026 SHALL, on the edge with RST_I=1 (including mid bus cycle), force state=BOOT, CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, FIFO empty, init_done=0, busy=0, err=0 and counters 0.
REQ-027 SHALL hold in_ready=0 while RST_I=1, then in_ready=1 from the first cycle after release.

Verification
REQ-028 Release reset with a UART model ACKing in 1 cycle -> write div=86 at ADR 6, then txctrl=0x1 at ADR 2, then init_done=1; no other bus traffic.
REQ-029 Push 0x48,0x69 after init, UART not full -> each byte gets a poll (ADR 0 read) then a write DAT_O=0x48, then 0x69; returns to IDLE, busy=0.
REQ-030 Model returns DAT_I[31]=1 for 2 polls -> two GAPs of exactly 16 idle cycles each, then a single write of the byte.
REQ-031 Push 5 bytes with FIFO_DEPTH=4 while the UART stalls -> in_ready=0 after the 4th; the 5th is accepted the edge after the first pop; all 5 emitted in order.
REQ-032 Model never ACKs the PUSH write -> CYC_O drops after 255 wait cycles, err=1, the byte is discarded, the next byte proceeds; err stays 1.
REQ-033 Assert RST_I mid-PUSH -> CYC_O=0 the next cycle, FIFO empty, and the init sequence repeats after release.
